// File: rtl/jts16_bus_pkg.sv
// Shared definitions for the System 16 bus-cycle controller.
// State encodings and the default open-bus read value.
package jts16_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } bus_st_e;

    localparam logic [15:0] OPEN_BUS_DEF = 16'hFFFF;

endpackage

// File: rtl/jts16_bus_mux.sv
// Registered one-hot read-data mux with load enable.
// An all-zero select loads the default (open bus) value.
module jts16_bus_mux #(
    parameter int NDEV = 8,
    parameter int DW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic [NDEV-1:0]    sel,
    input  logic [NDEV*DW-1:0] din,
    input  logic [DW-1:0]      def,
    output logic [DW-1:0]      q
);

    logic [DW-1:0] d;

    always_comb begin
        d = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (sel[i]) d = d | din[i*DW +: DW];
        end
        if (sel == '0) d = def;
    end

    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (ld) q <= d;
    end

endmodule

// File: rtl/jts16_bus_decode.sv
// 68000 bus-cycle controller: latches chip selects, waits, and
// answers with DTACKn or BERRn; read data goes through a registered mux.
import jts16_bus_pkg::*;

module jts16_bus_decode #(
    parameter int              NDEV     = 8,
    parameter int              DW       = 16,
    parameter logic [NDEV-1:0] OK_MASK  = {NDEV{1'b0}},
    parameter int              LAT      = 1,
    parameter int              TOUT     = 255,
    parameter logic [DW-1:0]   OPEN_BUS = {DW{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               asn,
    input  logic [1:0]         dsn,
    input  logic               rnw,
    input  logic [NDEV-1:0]    sel,
    input  logic [NDEV-1:0]    dev_ok,
    input  logic [NDEV*DW-1:0] dev_din,
    output logic [NDEV-1:0]    dev_cs,
    output logic [DW-1:0]      cpu_din,
    output logic               dtackn,
    output logic               berrn,
    output logic               unmapped,
    output logic [7:0]         st_lat
);

    localparam int CW = $clog2(TOUT + 1);

    bus_st_e         st_q, st_nx;
    logic [NDEV-1:0] cs_q, cs_nx, hit, mux_sel;
    logic [CW-1:0]   cnt_q, cnt_nx;
    logic [CW:0]     cnt_p1;
    logic [7:0]      lat_q, lat_nx;
    logic            rd_q, rd_nx, unm_q, unm_nx;
    logic            start, need_ok, got_ok, done, ld;

    assign start   = !asn && (rnw || dsn != 2'b11);
    assign hit     = sel & (-sel);
    assign need_ok = |(cs_q & OK_MASK);
    assign got_ok  = |(cs_q & dev_ok);
    // The first WAIT cycle's dev_ok may be left over from the previous access
    assign done    = need_ok ? (got_ok && cnt_q != '0)
                             : (cnt_q == CW'(LAT - 1));
    assign cnt_p1  = {1'b0, cnt_q} + 1'b1;

    always_comb begin
        st_nx   = st_q;
        cs_nx   = cs_q;
        cnt_nx  = cnt_q;
        rd_nx   = rd_q;
        lat_nx  = lat_q;
        unm_nx  = 1'b0;
        ld      = 1'b0;
        mux_sel = cs_q;
        unique case (st_q)
            ST_IDLE: begin
                cs_nx  = '0;
                cnt_nx = '0;
                if (start) begin
                    rd_nx = rnw;
                    if (|sel) begin
                        cs_nx = hit;
                        st_nx = ST_WAIT;
                    end else begin
                        unm_nx  = 1'b1;
                        ld      = rnw;
                        mux_sel = '0;
                        st_nx   = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt_q + 1'b1;
                if (asn) begin
                    cs_nx = '0;
                    st_nx = ST_IDLE;
                end else if (done) begin
                    ld     = rd_q;
                    lat_nx = (32'(cnt_p1) > 32'd255) ? 8'hFF : 8'(cnt_p1);
                    st_nx  = ST_ACK;
                end else if (cnt_q == CW'(TOUT - 1)) begin
                    cs_nx = '0;
                    st_nx = ST_ERR;
                end
            end
            ST_ACK, ST_ERR: begin
                if (asn) begin
                    cs_nx = '0;
                    st_nx = ST_IDLE;
                end
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            cs_q  <= '0;
            cnt_q <= '0;
            rd_q  <= 1'b0;
            lat_q <= '0;
            unm_q <= 1'b0;
        end else begin
            st_q  <= st_nx;
            cs_q  <= cs_nx;
            cnt_q <= cnt_nx;
            rd_q  <= rd_nx;
            lat_q <= lat_nx;
            unm_q <= unm_nx;
        end
    end

    jts16_bus_mux #(.NDEV(NDEV), .DW(DW)) u_mux (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .sel (mux_sel),
        .din (dev_din),
        .def (OPEN_BUS),
        .q   (cpu_din)
    );

    assign dev_cs   = cs_q;
    assign dtackn   = st_q != ST_ACK;
    assign berrn    = st_q != ST_ERR;
    assign unmapped = unm_q;
    assign st_lat   = lat_q;

    a_sel_onehot: assert property (@(posedge clk) disable iff (rst)
        (st_q == ST_IDLE && start) |-> $onehot0(sel));

endmodule
